uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one byte-wide UART transmitter among N AXI-stream byte sources. Arbitration is round-robin, and a grant is held for a whole packet, which ends on tlast. Each packet can be prefixed with a channel-ID header byte. After each packet the block waits for the transmitter to go idle, then inserts a programmable gap. It sits between the per-channel byte producers and the single UART TX block, whose s_axis input is driven from m_axis here.

Parameters:
N, 4, number of requesters (2..8)
ADD_HDR, 1, 1 = send a header byte before each packet; 0 = no header
HDR_BASE, 8'hA0, header byte value = HDR_BASE + granted index (8-bit wrap)
GAP_CYCLES, 16, idle clocks inserted after the transmitter goes idle (0 = none)
MAX_LEN, 64, maximum data bytes per grant before forced release (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  8*N  packed source bytes; channel i occupies bits [8i+7:8i]
s_axis_tvalid  in  N  per-source valid
s_axis_tlast  in  N  per-source last byte of packet
s_axis_tready  out  N  per-source ready; at most one bit set
m_axis_tdata  out  8  byte to the UART transmitter
m_axis_tvalid  out  1  byte valid to the UART transmitter
m_axis_tready  in  1  UART transmitter ready
tx_busy  in  1  UART transmitter busy (a frame is in flight)
grant_id  out  3  index of the current/last granted source
grant_active  out  1  high from HDR entry until the packet's last byte is accepted or forced release
len_err  out  1  one-cycle pulse on a forced release at MAX_LEN

Behaviour:
- Reset: state=IDLE, last_grant=N-1, grant_id=0, byte_cnt=0, gap_cnt=0.
- Reset outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, grant_active=0, len_err=0.
- Reset mid-packet aborts the packet at once; no further m_axis beats are produced.
- A beat transfers on any interface in the cycle where valid && ready.
- State IDLE:
  - Scan s_axis_tvalid starting at (last_grant+1) mod N, wrapping. The first asserted index wins.
  - Register the winner into grant_id and last_grant; set grant_active=1.
  - Go to HDR if ADD_HDR=1, else DATA. With no requests, stay in IDLE.
  - Arbitration costs 1 cycle; the first m_axis beat can appear in the cycle after the grant.
- State HDR:
  - m_axis_tvalid=1, m_axis_tdata=HDR_BASE+grant_id, all s_axis_tready=0.
  - On the m_axis handshake, go to DATA.
- State DATA:
  - Combinational pass-through of the granted channel: m_axis_tdata = s_axis_tdata[g]; m_axis_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = m_axis_tready. Other readies are 0.
  - byte_cnt increments on each handshake.
  - Handshake with s_axis_tlast[g]=1: go to GAP.
  - Handshake that makes byte_cnt reach MAX_LEN without tlast: pulse len_err for one cycle, then go to GAP. The rest of that packet is arbitrated later as a new packet.
  - Source tvalid low: hold the grant indefinitely; there is no timeout.
- State GAP:
  - On entry: grant_active=0, byte_cnt=0, m_axis_tvalid=0, all s_axis_tready=0.
  - Wait until tx_busy=0, then count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES=0, go to IDLE in the first cycle tx_busy=0 is seen.
- Arithmetic:
  - byte_cnt is 8 bits and compared for equality against MAX_LEN.
  - gap_cnt is 16 bits.
  - The header sum truncates to 8 bits.
- Simultaneous events:
  - tlast and MAX_LEN on the same beat counts as normal completion: len_err stays 0.
  - A request arriving in GAP is ignored until IDLE.
- Fairness: a source that asserts tvalid continuously while others also request waits at most N-1 packets for its grant.
- m_axis_tdata holds its last value while m_axis_tvalid=0.

Test Plan:
- Single source: ch2 sends bytes 0x11, 0x22 (tlast), ADD_HDR=1 -> m_axis carries 0xA2, 0x11, 0x22; grant_id=2; no m_axis beat for GAP_CYCLES clocks after tx_busy falls.
- All 4 sources assert tvalid continuously with 1-byte packets -> grant order 0,1,2,3,0; headers 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- Backpressure: m_axis_tready toggles every cycle during a 3-byte packet -> bytes delivered in order, none duplicated or lost; non-granted readies stay 0.
- MAX_LEN=4, ch1 sends 6 bytes with tlast on byte 6 -> len_err pulses on the 4th handshake; ch1 is later re-granted for bytes 5-6 with a fresh header.
- rst asserted mid-DATA -> next cycle: all outputs at reset values; ch0 granted first after reset.
- ADD_HDR=0, GAP_CYCLES=0, tx_busy held high 20 clocks after tlast -> IDLE entered only in the first cycle tx_busy=0; no header bytes emitted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N channel sources, the arbiter and the shared UART transmitter.
// The arbiter uses the master modport; the environment side uses slave.
interface uart_tx_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [8*N-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tlast;
    logic [N-1:0]   s_axis_tready;
    logic [7:0]     m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter among N byte sources,
// with an optional channel-ID header and a post-packet idle gap.
module uart_tx_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned ADD_HDR    = 1,
    parameter logic [7:0]  HDR_BASE   = 8'hA0,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_LEN    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus,
    input  logic                  tx_busy,
    output logic [2:0]            grant_id,
    output logic                  grant_active,
    output logic                  len_err
);
    localparam int unsigned GW = 3;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_GAP_WAIT,
        S_GAP_CNT
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   grant_id_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]      data_q;
    logic            grant_active_d;
    logic            len_err_d;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      m_data;
    logic            m_valid;
    logic [N-1:0]    s_ready;

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= int'(N); k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!win_found && bus.s_axis_tvalid[i] &&
                    ((int'(last_grant_q) + k) % int'(N)) == i) begin
                    win_found = 1'b1;
                    win_idx   = GW'(i);
                end
            end
        end
    end

    // Granted-channel mux.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_id == GW'(i)) begin
                sel_data  = bus.s_axis_tdata[8*i +: 8];
                sel_valid = bus.s_axis_tvalid[i];
                sel_last  = bus.s_axis_tlast[i];
            end
        end
    end

    // Next-state and datapath outputs; m_data defaults to the held byte.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id;
        byte_cnt_d     = byte_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        grant_active_d = grant_active;
        len_err_d      = 1'b0;
        m_valid        = 1'b0;
        m_data         = data_q;
        s_ready        = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_d     = win_idx;
                    last_grant_d   = win_idx;
                    grant_active_d = 1'b1;
                    byte_cnt_d     = '0;
                    state_d        = (ADD_HDR != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                m_valid = 1'b1;
                m_data  = HDR_BASE + 8'(grant_id);
                if (bus.m_axis_tready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                m_valid = sel_valid;
                if (sel_valid) begin
                    m_data = sel_data;
                end
                for (int i = 0; i < int'(N); i++) begin
                    s_ready[i] = (grant_id == GW'(i)) && bus.m_axis_tready;
                end
                if (sel_valid && bus.m_axis_tready) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    // tlast wins over the length limit on the same beat.
                    if (sel_last) begin
                        state_d = S_GAP_WAIT;
                    end else if (byte_cnt_d == 8'(MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = S_GAP_WAIT;
                    end
                    if (state_d == S_GAP_WAIT) begin
                        byte_cnt_d     = '0;
                        gap_cnt_d      = '0;
                        grant_active_d = 1'b0;
                    end
                end
            end
            S_GAP_WAIT: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_GAP_CNT;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_GAP_CNT: begin
                if (gap_cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = m_data;
    assign bus.s_axis_tready = s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(N - 1);
            grant_id     <= '0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            data_q       <= '0;
            grant_active <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id     <= grant_id_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= m_data;
            grant_active <= grant_active_d;
            len_err      <= len_err_d;
        end
    end
endmodule
